// File: rtl/ahb_master_if.sv
`default_nettype none
// ============================================================================
// Module   : ahb_master_if
// Brief    : Single-outstanding AHB-lite initiator. Converts a core-side
//            req/rsp handshake into one AHB address phase plus one data phase.
//            Optional wait-state timeout: define AHB_MASTER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

module ahb_master_if #(
    parameter int ADDR_W         = `AHB_ADDR_WIDTH,
    parameter int DATA_W         = `AHB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] haddr_m2s,
    output logic              hwrite,
    output logic              hsel,
    output logic [DATA_W-1:0] hdata_m2s,
    input  logic              hready,
    input  logic              hresp,
    input  logic [DATA_W-1:0] hrdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              w_accept;
    logic              w_complete;
    logic              w_timeout;

    assign w_accept   = req_valid & req_ready;
    assign w_complete = (r_state == ST_DATA) & hready;

`ifdef AHB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_tmo_cnt;
    logic             w_in_phase;

    assign w_in_phase = (r_state == ST_ADDR) | (r_state == ST_DATA);
    // Fires on the edge that closes the TIMEOUT_CYCLES-th consecutive stall.
    assign w_timeout  = w_in_phase & ~hready &
                        (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_tmo_cnt <= '0;
        end else if (w_in_phase & ~hready) begin
            r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
        end
    end
`else
    logic w_unused_tmo;

    assign w_timeout    = 1'b0;
    assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_ADDR;
            ST_ADDR: begin
                if (hready)         w_state_nxt = ST_DATA;
                else if (w_timeout) w_state_nxt = ST_RESP;
            end
            ST_DATA: begin
                if (hready | w_timeout) w_state_nxt = ST_RESP;
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr  <= req_addr;
                r_write <= req_write;
                r_wdata <= req_wdata;
            end
            if (w_complete) begin
                r_rsp_err   <= hresp;
                r_rsp_rdata <= (!r_write && !hresp) ? hrdata : '0;
            end else if (w_timeout) begin
                r_rsp_err   <= 1'b1;
                r_rsp_rdata <= '0;
            end
        end
    end

    // Held low during reset so the core never launches into a clearing FSM.
    assign req_ready = (r_state == ST_IDLE) & ~rst;
    assign hsel      = (r_state == ST_ADDR);
    assign haddr_m2s = r_addr;
    assign hwrite    = r_write;
    assign hdata_m2s = ((r_state == ST_DATA) && r_write) ? r_wdata : '0;
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: doc/ahb_master_if.md
# ahb_master_if

Single-outstanding AHB-lite initiator that turns a simple core-side request/response handshake into AHB address and data phases toward an `ahb_slave`-style responder. It drives `hsel`, `haddr_m2s`, `hwrite` and `hdata_m2s`, and samples `hready`, `hresp` and `hrdata`. It returns one response per request to the core side. It sits between the core's load/store or fetch unit and the AHB fabric.

## Interface
Parameters:
- `ADDR_W`, default `` `AHB_ADDR_WIDTH ``: AHB address width.
- `DATA_W`, default `` `AHB_DATA_WIDTH ``: AHB data width.
- `TIMEOUT_CYCLES`, default 16: wait-state limit. Used only when `AHB_MASTER_TIMEOUT_EN` is defined.

Ports:
- `clk` in 1: the block's single clock.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in 1: core request valid.
- `req_ready` out 1: block can accept a request.
- `req_write` in 1: 1 for write, 0 for read.
- `req_addr` in ADDR_W: request address.
- `req_wdata` in DATA_W: write data.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out DATA_W: read data, 0 for writes and on error.
- `rsp_err` out 1: the transfer ended in error.
- `haddr_m2s` out ADDR_W: AHB address.
- `hwrite` out 1: AHB write strobe.
- `hsel` out 1: address phase active.
- `hdata_m2s` out DATA_W: AHB write data.
- `hready` in 1: slave ready.
- `hresp` in 1: slave error.
- `hrdata` in DATA_W: slave read data.

## Operation
The block uses a four-state FSM: IDLE, ADDR, DATA, RESP.

- **IDLE:**
  - `req_ready`=1 (combinational from state). No other state asserts it.
  - On `req_valid & req_ready`, the block latches addr, write and wdata into holding registers and moves to ADDR.
- **ADDR:**
  - `hsel`=1. `haddr_m2s` and `hwrite` come from the latched values.
  - On an edge with `hready`=1, the address is accepted and the FSM moves to DATA. Otherwise it stays in ADDR with all outputs stable.
- **DATA:**
  - `hsel`=0. `hdata_m2s` = latched wdata for a write, 0 for a read.
  - On an edge with `hready`=1, the transfer completes and the FSM moves to RESP.
  - At completion, `rsp_err` ← `hresp`.
  - At completion, `rsp_rdata` ← `hrdata` for a read with `hresp`=0, otherwise 0.
- **RESP:**
  - `rsp_valid`=1 for exactly one cycle, then the FSM returns to IDLE.
  - `rsp_rdata` and `rsp_err` hold their values until the next completion.

Other rules:
- `haddr_m2s` and `hwrite` hold the last latched values until the next accept. `hdata_m2s` returns to 0 on leaving DATA.
- `hresp` and `hrdata` are ignored when `hready`=0 and outside DATA.
- `req_valid` asserted outside IDLE is not accepted. No request is queued.

## Timing
- Reset (`rst`=1 at an edge):
  - state=IDLE; `hsel`, `hwrite`, `rsp_valid`, `rsp_err` = 0; `haddr_m2s`, `hdata_m2s`, `rsp_rdata` = 0.
  - `req_ready`=0 while `rst` is high.
  - Reset asserted mid-transfer abandons the transfer with no `rsp_valid`. `hsel` is 0 in the cycle after the reset edge.
- Latency with zero wait states:
  - Accept edge at cycle 0.
  - ADDR in cycle 1, DATA in cycle 2, RESP (`rsp_valid`) in cycle 3.
  - `req_ready` high again in cycle 4.
- Each `hready`=0 cycle in ADDR or DATA adds exactly one cycle.
- Back-to-back requests issue at most one transfer every 4 cycles. There is no address/data phase overlap.

## Configuration
- `AHB_MASTER_TIMEOUT_EN` defined:
  - A counter clears on entry to ADDR and on entry to DATA, and increments on every `hready`=0 cycle in those states.
  - When the count reaches TIMEOUT_CYCLES, the FSM goes to RESP with `rsp_err`=1 and `rsp_rdata`=0, and drops `hsel`.
  - If `hready`=1 arrives on that same edge, normal completion wins.
- `AHB_MASTER_TIMEOUT_EN` undefined:
  - No counter is built, and the block waits indefinitely on `hready`=0.

## Test plan
- **Write, zero wait:** `req_write`=1, `req_addr`=0x1000, `req_wdata`=0xDEADBEEF, `hready`=1 throughout.
  - Expect `hsel`=1 with `haddr_m2s`=0x1000 in cycle 1.
  - Expect `hdata_m2s`=0xDEADBEEF in cycle 2.
  - Expect `rsp_valid`=1, `rsp_err`=0, `rsp_rdata`=0 in cycle 3.
- **Read with wait states:** read 0x2004; `hready`=0 for 2 DATA cycles; `hrdata`=0x12345678 on the completing edge.
  - Expect `rsp_valid` in cycle 5 with `rsp_rdata`=0x12345678.
- **Address-phase stall:** `hready`=0 for 3 cycles in ADDR.
  - Expect `hsel`, `haddr_m2s` and `hwrite` stable for 4 cycles, and `req_ready`=0 throughout.
- **Error response:** read with `hresp`=1 and `hready`=1 on the DATA edge.
  - Expect `rsp_err`=1 and `rsp_rdata`=0. Expect `req_ready`=1 on the following cycle.
- **Reset mid-DATA:** assert `rst` during DATA.
  - Expect no `rsp_valid`, all outputs 0 next cycle, and `req_ready`=1 after `rst` drops.
- **Timeout (macro defined, TIMEOUT_CYCLES=16):** hold `hready`=0 forever.
  - Expect `rsp_valid` with `rsp_err`=1 after 16 stalled ADDR cycles.
  - Without the macro, expect no `rsp_valid` after 100 cycles.
